// File: rtl/sum_acc_if.sv
// Stream bundle for sum_accumulator: per-pair sum input side and framed-total output side.
// The slave modport is the accumulator's view; the master modport is the producer/consumer view.
interface sum_acc_if #(
    parameter int SIZE  = 16,
    parameter int ACC_W = 19
);
    logic             in_valid;
    logic             in_ready;
    logic [SIZE:0]    in_sum;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [7:0]       out_beats;
    logic             out_ovf;

    modport master (
        output in_valid, in_sum, flush, out_ready,
        input  in_ready, out_valid, out_acc, out_beats, out_ovf
    );

    modport slave (
        input  in_valid, in_sum, flush, out_ready,
        output in_ready, out_valid, out_acc, out_beats, out_ovf
    );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates frames of COUNT adder sums (or fewer on flush) and presents the frame total.
// Optional macro SUM_ACC_SATURATE_EN: clamp the accumulator to all-ones on overflow instead of wrapping.
module sum_accumulator #(
    parameter int SIZE  = 16,
    parameter int COUNT = 4,
    parameter int ACC_W = 19
) (
    input  logic      clk,
    input  logic      rst_n,
    sum_acc_if.slave  bus
);
    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;
    localparam logic [7:0] COUNT_B  = 8'(COUNT);

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       beats_q, beats_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_acc_q, out_acc_d;
    logic [7:0]       out_beats_q, out_beats_d;
    logic             out_ovf_q, out_ovf_d;

    logic [SIZE:0]    in_sum_s;
    logic [ACC_W:0]   sum_s;
    logic [ACC_W-1:0] acc_new_s;
    logic             beat_s;
    logic             close_s;

    assign in_sum_s = bus.in_sum;

    // Widened add exposes the carry out of ACC_W; the overflow flag stays sticky for the frame.
    always_comb begin
        sum_s = {1'b0, acc_q} + (ACC_W + 1)'(in_sum_s);
`ifdef SUM_ACC_SATURATE_EN
        if (sum_s[ACC_W] || ovf_q) begin
            acc_new_s = {ACC_W{1'b1}};
        end else begin
            acc_new_s = sum_s[ACC_W-1:0];
        end
`else
        acc_new_s = sum_s[ACC_W-1:0];
`endif
    end

    // Next-state logic for the ACCUM/HOLD controller, running totals and result registers.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        beats_d     = beats_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_beats_d = out_beats_q;
        out_ovf_d   = out_ovf_q;
        beat_s      = 1'b0;
        close_s     = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                beat_s = bus.in_valid;
                if (beat_s) begin
                    acc_d   = acc_new_s;
                    beats_d = beats_q + 8'd1;
                    ovf_d   = ovf_q | sum_s[ACC_W];
                end else begin
                    acc_d   = acc_q;
                    beats_d = beats_q;
                    ovf_d   = ovf_q;
                end
                // A flush with nothing collected and no beat this cycle has no frame to close.
                close_s = (beat_s && (beats_d == COUNT_B)) || (bus.flush && (beats_d != 8'd0));
                if (close_s) begin
                    out_valid_d = 1'b1;
                    out_acc_d   = acc_d;
                    out_beats_d = beats_d;
                    out_ovf_d   = ovf_d;
                    state_d     = ST_HOLD;
                end else begin
                    state_d     = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = {ACC_W{1'b0}};
                    beats_d     = 8'd0;
                    ovf_d       = 1'b0;
                    state_d     = ST_ACCUM;
                end else begin
                    state_d     = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // State and output registers; reset discards any partial frame or pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            acc_q       <= {ACC_W{1'b0}};
            beats_q     <= 8'd0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= {ACC_W{1'b0}};
            out_beats_q <= 8'd0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            beats_q     <= beats_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_beats_q <= out_beats_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_ACCUM) && rst_n;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_beats = out_beats_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: a 19-bit instance for framing and a 18-bit instance for overflow.
module tb_sum_accumulator;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    sum_acc_if #(.SIZE(16), .ACC_W(19)) bus  ();
    sum_acc_if #(.SIZE(16), .ACC_W(18)) bus2 ();

    sum_accumulator #(.SIZE(16), .COUNT(4), .ACC_W(19)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    sum_accumulator #(.SIZE(16), .COUNT(4), .ACC_W(18)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;  bus.in_sum = 17'd0;  bus.flush = 1'b0;  bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_sum = 17'd0; bus2.flush = 1'b0; bus2.out_ready = 1'b1;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_acc, bus.out_beats, bus.out_ovf} !== {1'b0, 1'b0, 19'd0, 8'd0, 1'b0})
            $display("FAIL reset_state: got rdy=%0b v=%0b acc=%0d beats=%0d ovf=%0b, want all 0",
                     bus.in_ready, bus.out_valid, bus.out_acc, bus.out_beats, bus.out_ovf);
        else n_pass++;
        step();
        step();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_release_ready: got %0b want 1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_basic_frame();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_sum    = 17'd210;
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL basic_early_valid: got %0b want 0", bus.out_valid);
        else n_pass++;
        step();
        bus.in_valid = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.out_acc, bus.out_beats, bus.out_ovf, bus.in_ready} !== {1'b1, 19'd840, 8'd4, 1'b0, 1'b0})
            $display("FAIL basic_result: got v=%0b acc=%0d beats=%0d ovf=%0b rdy=%0b want v=1 acc=840 beats=4 ovf=0 rdy=0",
                     bus.out_valid, bus.out_acc, bus.out_beats, bus.out_ovf, bus.in_ready);
        else n_pass++;
        step();
        n_checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01)
            $display("FAIL basic_one_cycle: got v=%0b rdy=%0b want v=0 rdy=1", bus.out_valid, bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [17:0] exp_acc;
`ifdef SUM_ACC_SATURATE_EN
        exp_acc = 18'd262143;
`else
        exp_acc = 18'd262140;
`endif
        bus2.in_valid = 1'b1;
        bus2.in_sum   = 17'd131071;
        for (int i = 0; i < 4; i++) step();
        bus2.in_valid = 1'b0;
        n_checks++;
        if ({bus2.out_valid, bus2.out_acc, bus2.out_beats, bus2.out_ovf} !== {1'b1, exp_acc, 8'd4, 1'b1})
            $display("FAIL overflow_result: got v=%0b acc=%0d beats=%0d ovf=%0b want v=1 acc=%0d beats=4 ovf=1",
                     bus2.out_valid, bus2.out_acc, bus2.out_beats, bus2.out_ovf, exp_acc);
        else n_pass++;
        step();
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        bus.in_valid  = 1'b0;
        step();
        n_checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01)
            $display("FAIL flush_empty: got v=%0b rdy=%0b want v=0 rdy=1", bus.out_valid, bus.in_ready);
        else n_pass++;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sum   = 17'd210;
        step();
        bus.flush  = 1'b1;
        bus.in_sum = 17'd5;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.out_acc, bus.out_beats, bus.out_ovf} !== {1'b1, 19'd215, 8'd2, 1'b0})
            $display("FAIL flush_result: got v=%0b acc=%0d beats=%0d ovf=%0b want v=1 acc=215 beats=2 ovf=0",
                     bus.out_valid, bus.out_acc, bus.out_beats, bus.out_ovf);
        else n_pass++;
        step();
    endtask

    task automatic test_hold();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sum    = 17'd100;
        for (int i = 0; i < 4; i++) step();
        bus.in_sum = 17'd999;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({bus.out_valid, bus.out_acc, bus.out_beats, bus.out_ovf, bus.in_ready} !== {1'b1, 19'd400, 8'd4, 1'b0, 1'b0})
                $display("FAIL hold_stable[%0d]: got v=%0b acc=%0d beats=%0d rdy=%0b want v=1 acc=400 beats=4 rdy=0",
                         i, bus.out_valid, bus.out_acc, bus.out_beats, bus.in_ready);
            else n_pass++;
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        step();
        n_checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01)
            $display("FAIL hold_release: got v=%0b rdy=%0b want v=0 rdy=1", bus.out_valid, bus.in_ready);
        else n_pass++;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_sum = 17'(7 + i);
            step();
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.out_acc, bus.out_beats} !== {1'b1, 19'd34, 8'd4})
            $display("FAIL hold_next_frame: got v=%0b acc=%0d beats=%0d want v=1 acc=34 beats=4",
                     bus.out_valid, bus.out_acc, bus.out_beats);
        else n_pass++;
        step();
    endtask

    task automatic test_reset_midframe();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sum    = 17'd50;
        step();
        step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_acc, bus.out_beats, bus.out_ovf} !== {1'b0, 1'b0, 19'd0, 8'd0, 1'b0})
            $display("FAIL reset_midframe: got rdy=%0b v=%0b acc=%0d beats=%0d want all 0",
                     bus.in_ready, bus.out_valid, bus.out_acc, bus.out_beats);
        else n_pass++;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if ({bus.out_valid, bus.out_acc} !== {1'b1, 19'd200})
            $display("FAIL reset_reach_hold: got v=%0b acc=%0d want v=1 acc=200", bus.out_valid, bus.out_acc);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_acc, bus.out_beats, bus.out_ovf} !== {1'b0, 1'b0, 19'd0, 8'd0, 1'b0})
            $display("FAIL reset_in_hold: got rdy=%0b v=%0b acc=%0d beats=%0d want all 0",
                     bus.in_ready, bus.out_valid, bus.out_acc, bus.out_beats);
        else n_pass++;
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_sum    = 17'd1;
        for (int i = 0; i < 4; i++) step();
        bus.in_valid = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.out_acc, bus.out_beats} !== {1'b1, 19'd4, 8'd4})
            $display("FAIL reset_next_frame: got v=%0b acc=%0d beats=%0d want v=1 acc=4 beats=4",
                     bus.out_valid, bus.out_acc, bus.out_beats);
        else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        logic [16:0] tbl [10];
        tbl = '{17'd1, 17'd2, 17'd3, 17'd4, 17'd77, 17'd10, 17'd20, 17'd30, 17'd40, 17'd77};
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.in_sum = tbl[c];
            step();
            n_checks++;
            if (bus.out_valid !== ((c == 3) || (c == 8)))
                $display("FAIL b2b_valid[%0d]: got %0b want %0b", c, bus.out_valid, ((c == 3) || (c == 8)));
            else n_pass++;
            if (c == 3 || c == 8) begin
                n_checks++;
                if (bus.out_acc !== ((c == 3) ? 19'd10 : 19'd100))
                    $display("FAIL b2b_acc[%0d]: got %0d want %0d", c, bus.out_acc, ((c == 3) ? 10 : 100));
                else n_pass++;
            end
        end
        bus.in_valid = 1'b0;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_basic_frame();
        test_overflow();
        test_flush();
        test_hold();
        test_reset_midframe();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
